muldiv_unit: RTL
================

Name: muldiv_unit

Overview:
Iterative multiply/divide unit with architectural HI/LO registers. It sits beside alu in the execute stage and takes the same a/b operand bus and func_code field as alu (opcode 0 class).
- Executes MULT, MULTU, DIV, DIVU, MFHI, MFLO, MTHI and MTLO.
- Its registered out feeds the execute-stage result mux alongside alu's out.
- The control path must hold further starts while busy=1.

Parameters:
XLEN, 32, operand/HI/LO width; all constants below are for 32.
ITER, 32, datapath iterations per mul/div; equals XLEN.

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high; sampled on rising edge of clk
start  input  1  request strobe; qualifies func_code/a/b for one cycle
func_code  input  6  MIPS R-type funct field
a  input  32  rs operand (multiplicand / dividend / MTxx source)
b  input  32  rt operand (multiplier / divisor)
busy  output  1  mul/div iteration in progress
done  output  1  one-cycle pulse: HI/LO just updated by mul/div
out  output  32  MFHI/MFLO result, registered
hi  output  32  current HI register
lo  output  32  current LO register

Behaviour:
- Reset (synchronous, active-high, priority over everything): hi=0, lo=0, out=0, busy=0, done=0, state=IDLE, counter=0. Reset during RUN/FIX aborts the operation; no partial HI/LO write.
- Funct codes: MFHI 010000, MTHI 010001, MFLO 010010, MTLO 010011, MULT 011000, MULTU 011001, DIV 011010, DIVU 011011.
- Any start with another funct code: ignored; no state change.
- Start accepted only when state=IDLE. A start while busy=1 is ignored and not queued.
- States: IDLE -> RUN (mul/div accepted) -> FIX (after ITER iterations) -> IDLE.
- Latency: mul/div accepted on edge E0.
  - busy=1 from E0 through E33, i.e. 33 cycles in RUN+FIX.
  - E1..E32: one iteration per edge; 5-bit counter runs 0..31.
  - E33: sign-fix, write hi/lo; busy=0 and done=1 for exactly one cycle.
  - A new start may be accepted on E34, with done visible in that cycle.
- Multiply: unsigned shift-add over 64-bit accumulator.
  - MULT operates on |a|,|b| and negates the 64-bit product if sign(a)!=sign(b).
  - {hi,lo} = product[63:32], product[31:0].
- Divide: restoring, unsigned, on |a|,|b| (signed) or a,b (unsigned).
  - lo=quotient, hi=remainder.
  - DIV: quotient negated if signs differ; remainder takes the sign of a.
- Divide by zero (DIV or DIVU): lo=32'hFFFFFFFF, hi=a, no sign correction; same 33-cycle latency.
- DIV 32'h80000000 / 32'hFFFFFFFF: lo=32'h80000000, hi=0.
- MTHI/MTLO: single cycle. hi (resp. lo)=a on the accept edge; busy stays 0; done stays 0.
- MFHI/MFLO: out=hi (resp. lo) on the accept edge, visible the next cycle; out otherwise holds its last value.
- hi/lo outputs always reflect architectural registers. Intermediate accumulator state is internal; hi/lo are unchanged during RUN.
- Inputs a/b/func_code are captured at acceptance; changes during RUN have no effect.

Test Plan:
- MULT a=32'hFFFFFFFD (-3), b=7 -> busy high 33 cycles; done pulse; hi=32'hFFFFFFFF, lo=32'hFFFFFFEB. Then MFLO -> out=32'hFFFFFFEB next cycle.
- MULTU a=b=32'hFFFFFFFF -> hi=32'hFFFFFFFE, lo=32'h00000001 at done. Same operands with MULT -> hi=0, lo=1.
- DIV a=32'hFFFFFFF9 (-7), b=2 -> lo=32'hFFFFFFFD, hi=32'hFFFFFFFF.
  - DIVU a=100, b=0 -> lo=32'hFFFFFFFF, hi=32'h00000064.
  - DIV a=32'h80000000, b=32'hFFFFFFFF -> lo=32'h80000000, hi=0.
- MTHI a=32'h12345678, then MFHI -> out=32'h12345678 one cycle after MFHI. busy/done never assert; lo unchanged.
- DIVU a=50, b=7; assert start with MTLO a=1 at cycle 5 of busy -> MTLO ignored. done yields lo=7, hi=1; lo is not 1 afterwards.
- MULTU a=b=3; assert reset for one cycle at cycle 10 of busy -> next cycle busy=0, hi=lo=out=0, done never pulses. A following MULTU 3*3 gives lo=9, hi=0.

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// One shift-add or restoring-divide step per cycle, then a single sign-fix cycle.
module muldiv_unit #(
   parameter int XLEN = 32,
   parameter int ITER = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic [5:0]      func_code,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] out,
   output logic [XLEN-1:0] hi,
   output logic [XLEN-1:0] lo
);

   localparam int CW = $clog2(ITER);
   localparam logic [CW-1:0] LAST = CW'(ITER - 1);

   localparam logic [5:0] F_MFHI  = 6'b010000;
   localparam logic [5:0] F_MTHI  = 6'b010001;
   localparam logic [5:0] F_MFLO  = 6'b010010;
   localparam logic [5:0] F_MTLO  = 6'b010011;
   localparam logic [5:0] F_MULT  = 6'b011000;
   localparam logic [5:0] F_MULTU = 6'b011001;
   localparam logic [5:0] F_DIV   = 6'b011010;
   localparam logic [5:0] F_DIVU  = 6'b011011;

   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FIX = 2'd2} state_t;

   state_t                state_q, state_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic [2*XLEN-1:0]     acc_q, acc_d;
   logic [XLEN-1:0]       opnd_q, opnd_d;
   logic                  is_div_q, is_div_d;
   logic                  neg_q, neg_d;
   logic                  neg_rem_q, neg_rem_d;
   logic                  div0_q, div0_d;
   logic [XLEN-1:0]       hi_q, hi_d;
   logic [XLEN-1:0]       lo_q, lo_d;
   logic [XLEN-1:0]       out_q, out_d;
   logic                  done_q, done_d;

   logic                  accept;
   logic                  md_op;
   logic                  signed_op;
   logic [XLEN-1:0]       abs_a, abs_b;
   logic [XLEN:0]         mul_sum;
   logic [XLEN:0]         rem_sh, rem_diff;
   logic                  rem_ge;
   logic [2*XLEN-1:0]     mul_step, div_step;

   assign accept    = start && (state_q == IDLE);
   assign md_op     = func_code inside {F_MULT, F_MULTU, F_DIV, F_DIVU};
   // Even funct codes of the mul/div group are the signed variants.
   assign signed_op = ~func_code[0];
   assign abs_a     = (signed_op && a[XLEN-1]) ? -a : a;
   assign abs_b     = (signed_op && b[XLEN-1]) ? -b : b;

   // Multiply: {partial, multiplier} shifts right, adding the multiplicand on a set LSB.
   assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, (acc_q[0] ? opnd_q : '0)};
   assign mul_step = {mul_sum, acc_q[XLEN-1:1]};

   // Divide: {remainder, quotient} shifts left; a quotient bit is set when the trial subtract fits.
   assign rem_sh   = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
   assign rem_ge   = rem_sh >= {1'b0, opnd_q};
   assign rem_diff = rem_sh - {1'b0, opnd_q};
   assign div_step = {(rem_ge ? rem_diff[XLEN-1:0] : rem_sh[XLEN-1:0]), acc_q[XLEN-2:0], rem_ge};

   always_ff @(posedge clk) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept && md_op) state_d = RUN;
         RUN:     if (cnt_q == LAST) state_d = FIX;
         FIX:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      busy = (state_q != IDLE);
      done = done_q;
      out  = out_q;
      hi   = hi_q;
      lo   = lo_q;
   end

   always_comb begin
      cnt_d     = cnt_q;
      acc_d     = acc_q;
      opnd_d    = opnd_q;
      is_div_d  = is_div_q;
      neg_d     = neg_q;
      neg_rem_d = neg_rem_q;
      div0_d    = div0_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      out_d     = out_q;
      done_d    = 1'b0;
      case (state_q)
         IDLE: begin
            if (accept) begin
               case (func_code)
                  F_MFHI: out_d = hi_q;
                  F_MFLO: out_d = lo_q;
                  F_MTHI: hi_d  = a;
                  F_MTLO: lo_d  = a;
                  F_MULT, F_MULTU, F_DIV, F_DIVU: begin
                     is_div_d  = func_code[1];
                     opnd_d    = func_code[1] ? abs_b : abs_a;
                     acc_d     = {{XLEN{1'b0}}, (func_code[1] ? abs_a : abs_b)};
                     neg_d     = signed_op && (a[XLEN-1] ^ b[XLEN-1]);
                     neg_rem_d = signed_op && a[XLEN-1];
                     div0_d    = (b == '0);
                     cnt_d     = '0;
                  end
                  default: ;
               endcase
            end
         end
         RUN: begin
            acc_d = is_div_q ? div_step : mul_step;
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
         end
         FIX: begin
            done_d = 1'b1;
            if (is_div_q) begin
               // Divide by zero leaves remainder = |a|, so the remainder sign fix restores a.
               lo_d = div0_q ? '1 : (neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0]);
               hi_d = neg_rem_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
            end else begin
               {hi_d, lo_d} = neg_q ? -acc_q : acc_q;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q     <= '0;
         acc_q     <= '0;
         opnd_q    <= '0;
         is_div_q  <= 1'b0;
         neg_q     <= 1'b0;
         neg_rem_q <= 1'b0;
         div0_q    <= 1'b0;
         hi_q      <= '0;
         lo_q      <= '0;
         out_q     <= '0;
         done_q    <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         acc_q     <= acc_d;
         opnd_q    <= opnd_d;
         is_div_q  <= is_div_d;
         neg_q     <= neg_d;
         neg_rem_q <= neg_rem_d;
         div0_q    <= div0_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         out_q     <= out_d;
         done_q    <= done_d;
      end
   end

endmodule
